// File: rtl/fifo_pkg.sv
// Shared sizing for the SRAM-backed FIFO: data/address widths and the occupancy type.
package fifo_pkg;
   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;

   // One extra bit so a completely full FIFO (16) is representable.
   typedef logic [AW:0] cnt_t;
endpackage

// File: rtl/fifo_mem.sv
// 16 x DW dual-port storage: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old byte.
module fifo_mem
   import fifo_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          wen,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          ren,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_d, rdata_q;

   always_comb begin
      rdata_d = rdata_q;
      if (ren) rdata_d = mem_q[raddr];
   end

   // Storage is intentionally not reset; only the output register is.
   always_ff @(posedge clk) begin
      if (wen) mem_q[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller over fifo_mem: pointers, occupancy, registered flags and
// one-cycle pop_valid / overflow / underflow strobes.
module sram_fifo_ctrl
   import fifo_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   output logic          full,
   input  logic          pop,
   output logic [DW-1:0] pop_data,
   output logic          pop_valid,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          overflow,
   output logic          underflow
);
   logic [AW-1:0] wptr_d, wptr_q, rptr_d, rptr_q;
   cnt_t          count_d, count_q;
   logic          full_d, full_q, empty_d, empty_q;
   logic          pop_valid_d, pop_valid_q;
   logic          overflow_d, overflow_q, underflow_d, underflow_q;
   logic          pop_acc, push_acc;

   always_comb begin
      pop_acc     = pop && !empty_q;
      // A pop in the same cycle frees the slot, so a full FIFO may still take a push.
      push_acc    = push && (!full_q || pop_acc);
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      if (push_acc) wptr_d = wptr_q + AW'(1);
      if (pop_acc)  rptr_d = rptr_q + AW'(1);
      case ({push_acc, pop_acc})
         2'b10:   count_d = count_q + cnt_t'(1);
         2'b01:   count_d = count_q - cnt_t'(1);
         default: count_d = count_q;
      endcase
      full_d      = (count_d == cnt_t'(DEPTH));
      empty_d     = (count_d == '0);
      pop_valid_d = pop_acc;
      overflow_d  = push && !push_acc;
      underflow_d = pop && !pop_acc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         pop_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         pop_valid_q <= pop_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   fifo_mem u_mem (
      .clk   (clk),
      .rst   (rst),
      .wen   (push_acc && !rst),
      .waddr (wptr_q),
      .wdata (push_data),
      .ren   (pop_acc && !rst),
      .raddr (rptr_q),
      .rdata (pop_data)
   );

   assign full      = full_q;
   assign empty     = empty_q;
   assign count     = count_q;
   assign pop_valid = pop_valid_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl: hand-computed checks plus a queue
// scoreboard for the mixed push/pop and steady-stream phases.
module tb_sram_fifo_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       push = 1'b0, pop = 1'b0;
   logic [7:0] push_data = 8'h00;
   logic       full, empty, pop_valid, overflow, underflow;
   logic [7:0] pop_data;
   logic [4:0] count;

   int tests = 0;
   int fails = 0;

   logic [7:0] mq [$];
   logic [7:0] m_pd;

   sram_fifo_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .full      (full),
      .pop       (pop),
      .pop_data  (pop_data),
      .pop_valid (pop_valid),
      .empty     (empty),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply inputs for one cycle, then sample 1 time unit after the edge.
   task automatic step(input logic r, input logic p, input logic [7:0] d, input logic po);
      rst = r; push = p; push_data = d; pop = po;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_flags(input string tag, input int c, input logic e, input logic f,
                            input logic pv, input logic ov, input logic un);
      chk({tag, ".count"}, 32'(count), 32'(c));
      chk({tag, ".empty"}, 32'(empty), 32'(e));
      chk({tag, ".full"}, 32'(full), 32'(f));
      chk({tag, ".pop_valid"}, 32'(pop_valid), 32'(pv));
      chk({tag, ".overflow"}, 32'(overflow), 32'(ov));
      chk({tag, ".underflow"}, 32'(underflow), 32'(un));
   endtask

   // Scoreboard step: predict acceptance from the queue, then compare everything.
   task automatic mstep(input string tag, input logic p, input logic [7:0] d, input logic po);
      logic pa, wa;
      pa = po && (mq.size() > 0);
      wa = p && ((mq.size() < 16) || pa);
      if (pa) m_pd = mq.pop_front();
      if (wa) mq.push_back(d);
      step(1'b0, p, d, po);
      chk_flags(tag, mq.size(), mq.size() == 0, mq.size() == 16, pa, p && !wa, po && !pa);
      chk({tag, ".pop_data"}, 32'(pop_data), 32'(m_pd));
   endtask

   initial begin
      // Reset state
      step(1'b1, 1'b0, 8'h00, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b0);
      chk_flags("reset", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("reset.pop_data", 32'(pop_data), 32'h0);

      // Fill 0x01..0x10
      for (int i = 1; i <= 16; i++) begin
         step(1'b0, 1'b1, 8'(i), 1'b0);
         chk("fill.count", 32'(count), 32'(i));
         chk("fill.empty", 32'(empty), 32'h0);
      end
      chk("fill.full", 32'(full), 32'h1);

      // 17th push rejected
      step(1'b0, 1'b1, 8'hAA, 1'b0);
      chk_flags("ovf", 16, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("ovf_pulse_end", 32'(overflow), 32'h0);

      // Push+pop at full: old head comes out, count stays 16
      step(1'b0, 1'b1, 8'h55, 1'b1);
      chk_flags("fullpp", 16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("fullpp.pop_data", 32'(pop_data), 32'h01);

      // Drain: 0x02..0x10 then 0x55
      for (int i = 2; i <= 17; i++) begin
         step(1'b0, 1'b0, 8'h00, 1'b1);
         chk("drain.pop_valid", 32'(pop_valid), 32'h1);
         chk("drain.pop_data", 32'(pop_data), (i == 17) ? 32'h55 : 32'(i));
         chk("drain.count", 32'(count), 32'(17 - i));
      end
      chk("drain.empty", 32'(empty), 32'h1);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("idle.pop_valid", 32'(pop_valid), 32'h0);
      chk("idle.pop_data_hold", 32'(pop_data), 32'h55);

      // Push+pop at empty: pop rejected, push taken
      step(1'b0, 1'b1, 8'h3C, 1'b1);
      chk_flags("emptypp", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk_flags("emptypp.pop", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("emptypp.pop_data", 32'(pop_data), 32'h3C);

      // Mid-stream reset with count = 5
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'(8'hA0 + i), 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk("pre_rst.count", 32'(count), 32'd5);
      chk("pre_rst.pop_data", 32'(pop_data), 32'hA0);
      step(1'b1, 1'b1, 8'hEE, 1'b1);
      step(1'b1, 1'b1, 8'hEE, 1'b1);
      chk_flags("midrst", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("midrst.pop_data", 32'(pop_data), 32'h0);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk_flags("midrst.pop", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

      // Mixed push/pop: 36 pushes and 34 pops from pointer 0, so both wrap twice
      mq.delete();
      m_pd = 8'h00;
      for (int i = 0; i < 40; i++)
         mstep("wrap", (i % 10) != 9, 8'(8'h40 + i), (i >= 2) && ((i % 10) != 4));

      // Steady stream at count 3
      for (int i = 0; i < 17 && mq.size() > 0; i++) mstep("sdrain", 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 3; i++) mstep("sfill", 1'b1, 8'(8'hC0 + i), 1'b0);
      for (int i = 0; i < 20; i++) begin
         mstep("stream", 1'b1, 8'(8'hD0 + i), 1'b1);
         chk("stream.pop_valid", 32'(pop_valid), 32'h1);
         chk("stream.count", 32'(count), 32'd3);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sram_fifo_ctrl.md
# sram_fifo_ctrl

Synchronous FIFO controller that sequences a 16 x 8 dual-port SRAM as a first-in/first-out buffer. It owns the write and read pointers, the occupancy count and the full/empty flags. Each accepted push becomes an SRAM write and each accepted pop becomes an SRAM read. It sits between a byte producer and a byte consumer that share one clock, and gives both a simple push/pop interface with no address handling.

## Interface
- DW, 8, data width in bits
- AW, 4, address width; depth = 2**AW = 16
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high
- push  input  1  write request
- push_data  input  DW  byte to enqueue; sampled with push
- full  output  1  high when count == 16
- pop  input  1  read request
- pop_data  output  DW  dequeued byte; valid when pop_valid
- pop_valid  output  1  one-cycle strobe: pop_data carries the byte from the pop accepted in the previous cycle
- empty  output  1  high when count == 0
- count  output  AW+1  current occupancy, 0..16
- overflow  output  1  one-cycle pulse: push rejected
- underflow  output  1  one-cycle pulse: pop rejected

## Operation
- Acceptance rules:
  - pop_acc = pop && !empty.
  - push_acc = push && (!full || pop_acc). Push is allowed at full only when a pop is accepted in the same cycle.
- Rejection:
  - push && !push_acc: overflow = 1 next cycle; no state change from that push.
  - pop && !pop_acc: underflow = 1 next cycle.
- push_acc: SRAM write mem[wptr] <= push_data; wptr <= wptr + 1 (mod 16).
- pop_acc: SRAM read pop_data <= mem[rptr]; rptr <= rptr + 1 (mod 16).
- Pointers are AW bits and wrap 15 -> 0 naturally. No extra wrap bit; count disambiguates full from empty.
- Count update:
  - push_acc only: count + 1.
  - pop_acc only: count - 1.
  - both, or neither: unchanged.
- full and empty are registered and derived from the next-state count. They are never combinational from push/pop.
- Simultaneous push_acc and pop_acc at full means wptr == rptr. The read returns the old (stored) byte and the write then replaces it (read-before-write).
- Push and pop on empty: the push is accepted, the pop is rejected with underflow. There is no bypass path.
- pop_data holds its last value when no pop is accepted.
- No state machine beyond pointer/count registers. The mode is implied by count: EMPTY (0), PARTIAL (1..15), FULL (16).

## Timing
- Reset (rst high at a rising edge), values after the edge:
  - wptr = 0, rptr = 0, count = 0.
  - empty = 1, full = 0.
  - pop_valid = 0, pop_data = 0.
  - overflow = 0, underflow = 0.
  - SRAM contents are not cleared.
- rst has priority over push and pop in the same cycle. Requests in that cycle are dropped with no error pulses.
- Reset mid-operation discards all stored data. The next pop after reset underflows until a push is made.
- Write latency: a byte pushed in cycle N is poppable in cycle N+1 (empty deasserts after edge N).
- Read latency: a pop accepted in cycle N gives pop_data/pop_valid in cycle N+1.
- Back-to-back pops every cycle give a pop_valid every cycle.
- full/empty/count reflect all accepted operations up to and including the previous edge.
- overflow/underflow are single-cycle pulses, asserted in the cycle after the rejected request.

## Structure
- Shared package fifo_pkg:
  - DW, AW, DEPTH constants.
  - Occupancy-count type of width AW+1.
- One sub-module, fifo_mem: 16 x DW storage.
  - Separate write port (wen, waddr, wdata) and read port (ren, raddr).
  - Registered rdata updated only on ren; read-before-write on the same address.
- sram_fifo_ctrl contains only:
  - Pointers and count.
  - Flag registers and the accept logic.
  - pop_valid/error pulse registers.

## Test plan
- Reset: assert rst for 2 cycles mid-stream with count = 5 -> count = 0, empty = 1, full = 0, pop_valid = 0, pop_data = 0. A following pop gives an underflow pulse and no pop_valid.
- Fill/overflow: push 0x01..0x10 on 16 consecutive cycles:
  - full = 1, count = 16.
  - A 17th push (0xAA) -> overflow pulse, count stays 16.
  - Draining 16 pops returns 0x01..0x10 in order, each one cycle after its pop, then empty = 1.
- Full push+pop: at full with head 0x01, push 0x55 and pop together -> pop_data = 0x01 next cycle, count stays 16, no overflow. A later drain ends with 0x55.
- Empty push+pop: at empty, push 0x3C with pop -> underflow pulse, count = 1. The next pop returns 0x3C.
- Wrap-around: 40 cycles of a random push/pop mix, counter-pattern data, checked against a reference queue:
  - Pointers cross 15 -> 0 at least twice.
  - Data order and count match at every cycle.
- Steady stream: push and pop every cycle with count held at 3 -> pop_valid stays high continuously with in-order data, and full/empty never assert.
